axi_elastic_cut: RTL and testbench

Per-channel configurable AXI4 / AXI4-Lite register stage that generalises the single-entry channel cut. Each of the five channels gets its own buffer depth:
- depth 0 is a plain wire;
- depth ≥2 is a fully decoupled FIFO with registered outputs.

The block also adds transaction accounting and an isolate/drain mode. It sits between a master-side and a slave-side AXI port on long interconnect paths, and at clock-gating or power boundaries where traffic must be quiesced before a domain is switched off.

---
 rtl/axi_elastic_cut_if.sv | 63 ++++++
 rtl/axi_elastic_cut.sv | 184 ++++++++++++++++++
 tb/tb_axi_elastic_cut.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_elastic_cut_if.sv
// AXI4 channel bundle used on both ports of axi_elastic_cut.
// Channel payloads are packed structs; last is the LSB of the W and R payloads.
interface axi_elastic_cut_if #(
  parameter int IdWidth   = 2,
  parameter int AddrWidth = 16,
  parameter int DataWidth = 16
);

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
  } aw_chan_t;

  typedef aw_chan_t ar_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] strb;
    logic                   last;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [1:0]         resp;
  } b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
  } r_chan_t;

  logic     aw_valid;
  logic     aw_ready;
  aw_chan_t aw;
  logic     w_valid;
  logic     w_ready;
  w_chan_t  w;
  logic     b_valid;
  logic     b_ready;
  b_chan_t  b;
  logic     ar_valid;
  logic     ar_ready;
  ar_chan_t ar;
  logic     r_valid;
  logic     r_ready;
  r_chan_t  r;

  modport master (
    output aw_valid, aw, w_valid, w, ar_valid, ar, b_ready, r_ready,
    input  aw_ready, w_ready, ar_ready, b_valid, b, r_valid, r
  );

  modport slave (
    input  aw_valid, aw, w_valid, w, ar_valid, ar, b_ready, r_ready,
    output aw_ready, w_ready, ar_ready, b_valid, b, r_valid, r
  );

endinterface

// File: rtl/axi_elastic_cut.sv
// Per-channel configurable AXI register stage with outstanding-transaction
// accounting and an isolate/drain mode for quiescing a port before power-down.
module axi_elastic_cut_fifo #(
  parameter int Depth = 2,
  parameter int Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data,
  output logic             empty
);

  if (Depth == 1 || Depth < 0) begin : g_illegal
    $error("axi_elastic_cut_fifo: Depth must be 0 (bypass) or at least 2");
  end else if (Depth == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_i;
    assign out_valid      = in_valid;
    assign in_ready       = out_ready;
    assign out_data       = in_data;
    assign empty          = 1'b1;
  end else begin : g_fifo
    localparam int PtrW = $clog2(Depth);
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [CntW-1:0]  count;
    logic             push;
    logic             pop;

    // Handshake outputs depend only on count, so no comb path crosses the stage.
    assign in_ready  = (count != CntW'(Depth));
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign empty     = (count == '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + PtrW'(1);
        if (pop)  rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + PtrW'(1);
        if (push && !pop)      count <= count + CntW'(1);
        else if (pop && !push) count <= count - CntW'(1);
      end
    end
  end

endmodule

module axi_elastic_cut #(
  parameter int AwDepth   = 2,
  parameter int WDepth    = 2,
  parameter int BDepth    = 2,
  parameter int ArDepth   = 2,
  parameter int RDepth    = 2,
  parameter int MaxWrTxn  = 8,
  parameter int MaxRdTxn  = 8,
  parameter int IdWidth   = 2,
  parameter int AddrWidth = 16,
  parameter int DataWidth = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               isolate_i,
  output logic               isolated_o,
  axi_elastic_cut_if.slave   slv,
  axi_elastic_cut_if.master  mst
);

  localparam int AxW    = IdWidth + AddrWidth + 13;
  localparam int WW     = DataWidth + DataWidth / 8 + 1;
  localparam int BW     = IdWidth + 2;
  localparam int RW     = IdWidth + DataWidth + 3;
  localparam int WrCntW = $clog2(MaxWrTxn + 1);
  localparam int RdCntW = $clog2(MaxRdTxn + 1);

  if (MaxWrTxn < 1 || MaxRdTxn < 1) begin : g_bad_txn
    $error("axi_elastic_cut: MaxWrTxn and MaxRdTxn must be at least 1");
  end

  logic              aw_allow;
  logic              ar_allow;
  logic              aw_in_ready;
  logic              ar_in_ready;
  logic              aw_empty;
  logic              w_empty;
  logic              b_empty;
  logic              ar_empty;
  logic              r_empty;
  logic              aw_hs;
  logic              b_hs;
  logic              ar_hs;
  logic              r_last_hs;
  logic              idle;
  logic [WrCntW-1:0] wr_cnt;
  logic [RdCntW-1:0] rd_cnt;

  // New requests are blocked while isolating or at the outstanding limit.
  assign aw_allow     = ~isolate_i & (wr_cnt != WrCntW'(MaxWrTxn));
  assign ar_allow     = ~isolate_i & (rd_cnt != RdCntW'(MaxRdTxn));
  assign slv.aw_ready = aw_in_ready & aw_allow;
  assign slv.ar_ready = ar_in_ready & ar_allow;

  axi_elastic_cut_fifo #(.Depth(AwDepth), .Width(AxW)) u_aw (
    .clk_i, .rst_i,
    .in_valid (slv.aw_valid & aw_allow), .in_ready (aw_in_ready), .in_data (slv.aw),
    .out_valid(mst.aw_valid), .out_ready(mst.aw_ready), .out_data(mst.aw),
    .empty    (aw_empty)
  );

  axi_elastic_cut_fifo #(.Depth(WDepth), .Width(WW)) u_w (
    .clk_i, .rst_i,
    .in_valid (slv.w_valid), .in_ready (slv.w_ready), .in_data (slv.w),
    .out_valid(mst.w_valid), .out_ready(mst.w_ready), .out_data(mst.w),
    .empty    (w_empty)
  );

  axi_elastic_cut_fifo #(.Depth(BDepth), .Width(BW)) u_b (
    .clk_i, .rst_i,
    .in_valid (mst.b_valid), .in_ready (mst.b_ready), .in_data (mst.b),
    .out_valid(slv.b_valid), .out_ready(slv.b_ready), .out_data(slv.b),
    .empty    (b_empty)
  );

  axi_elastic_cut_fifo #(.Depth(ArDepth), .Width(AxW)) u_ar (
    .clk_i, .rst_i,
    .in_valid (slv.ar_valid & ar_allow), .in_ready (ar_in_ready), .in_data (slv.ar),
    .out_valid(mst.ar_valid), .out_ready(mst.ar_ready), .out_data(mst.ar),
    .empty    (ar_empty)
  );

  axi_elastic_cut_fifo #(.Depth(RDepth), .Width(RW)) u_r (
    .clk_i, .rst_i,
    .in_valid (mst.r_valid), .in_ready (mst.r_ready), .in_data (mst.r),
    .out_valid(slv.r_valid), .out_ready(slv.r_ready), .out_data(slv.r),
    .empty    (r_empty)
  );

  assign aw_hs     = slv.aw_valid & slv.aw_ready;
  assign b_hs      = slv.b_valid & slv.b_ready;
  assign ar_hs     = slv.ar_valid & slv.ar_ready;
  assign r_last_hs = slv.r_valid & slv.r_ready & slv.r.last;
  assign idle      = aw_empty & w_empty & b_empty & ar_empty & r_empty &
                     (wr_cnt == '0) & (rd_cnt == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      isolated_o <= 1'b0;
    end else begin
      if (aw_hs && !b_hs)      wr_cnt <= wr_cnt + WrCntW'(1);
      else if (b_hs && !aw_hs) wr_cnt <= wr_cnt - WrCntW'(1);
      if (ar_hs && !r_last_hs)      rd_cnt <= rd_cnt + RdCntW'(1);
      else if (r_last_hs && !ar_hs) rd_cnt <= rd_cnt - RdCntW'(1);
      isolated_o <= isolate_i & idle;
    end
  end

`ifndef SYNTHESIS
  // Overflow is unreachable through the gating; underflow means a response with no request.
  a_wr_cnt_range : assert property (@(posedge clk_i) disable iff (rst_i)
    !((aw_hs && !b_hs && wr_cnt == WrCntW'(MaxWrTxn)) || (b_hs && !aw_hs && wr_cnt == '0)));
  a_rd_cnt_range : assert property (@(posedge clk_i) disable iff (rst_i)
    !((ar_hs && !r_last_hs && rd_cnt == RdCntW'(MaxRdTxn)) || (r_last_hs && !ar_hs && rd_cnt == '0)));
`endif

endmodule

// File: tb/tb_axi_elastic_cut.sv
// Directed bench for axi_elastic_cut: AW depth 3, W bypass, R depth 5, read limit 2.
module tb_axi_elastic_cut;

  localparam int IdW   = 2;
  localparam int AddrW = 16;
  localparam int DataW = 16;

  logic clk_i = 1'b0;
  logic rst_i;
  logic isolate_i;
  logic isolated_o;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   acc;
  logic got;

  axi_elastic_cut_if #(.IdWidth(IdW), .AddrWidth(AddrW), .DataWidth(DataW)) slv_bus ();
  axi_elastic_cut_if #(.IdWidth(IdW), .AddrWidth(AddrW), .DataWidth(DataW)) mst_bus ();

  axi_elastic_cut #(
    .AwDepth(3), .WDepth(0), .BDepth(2), .ArDepth(2), .RDepth(5),
    .MaxWrTxn(16), .MaxRdTxn(2),
    .IdWidth(IdW), .AddrWidth(AddrW), .DataWidth(DataW)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .isolate_i (isolate_i),
    .isolated_o(isolated_o),
    .slv       (slv_bus),
    .mst       (mst_bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  task automatic idle_inputs();
    slv_bus.aw_valid = 1'b0; slv_bus.aw = '0;
    slv_bus.w_valid  = 1'b0; slv_bus.w  = '0;
    slv_bus.ar_valid = 1'b0; slv_bus.ar = '0;
    slv_bus.b_ready  = 1'b0; slv_bus.r_ready = 1'b0;
    mst_bus.aw_ready = 1'b0; mst_bus.w_ready = 1'b0; mst_bus.ar_ready = 1'b0;
    mst_bus.b_valid  = 1'b0; mst_bus.b = '0;
    mst_bus.r_valid  = 1'b0; mst_bus.r = '0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    isolate_i = 1'b0;
    idle_inputs();
    cyc();
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    isolate_i = 1'b0;
    idle_inputs();
    #3;
    chk("rst_mst_aw_valid", 32'(mst_bus.aw_valid), 0);
    chk("rst_mst_ar_valid", 32'(mst_bus.ar_valid), 0);
    chk("rst_slv_b_valid",  32'(slv_bus.b_valid), 0);
    chk("rst_slv_r_valid",  32'(slv_bus.r_valid), 0);
    chk("rst_isolated",     32'(isolated_o), 0);
    chk("rst_aw_ready",     32'(slv_bus.aw_ready), 1);
    chk("rst_ar_ready",     32'(slv_bus.ar_ready), 1);
    chk("rst_b_fifo_ready", 32'(mst_bus.b_ready), 1);
    chk("rst_r_fifo_ready", 32'(mst_bus.r_ready), 1);
    slv_bus.w_valid = 1'b1; slv_bus.w.data = 16'h5A5A; mst_bus.w_ready = 1'b0;
    #1;
    chk("rst_w_bypass_valid", 32'(mst_bus.w_valid), 1);
    chk("rst_w_bypass_data",  32'(mst_bus.w.data), 32'h5A5A);
    chk("rst_w_bypass_ready", 32'(slv_bus.w_ready), 0);
    isolate_i = 1'b1;
    #1;
    chk("rst_iso_aw_ready", 32'(slv_bus.aw_ready), 0);
    chk("rst_iso_ar_ready", 32'(slv_bus.ar_ready), 0);
    isolate_i = 1'b0;
    idle_inputs();
    cyc();
    rst_i = 1'b0;

    // Throughput: 16 back-to-back AW+W beats, master always ready
    mst_bus.aw_ready = 1'b1; mst_bus.w_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      slv_bus.aw_valid = 1'b1; slv_bus.aw.addr = 16'(32'h0100 + i); slv_bus.aw.id = 2'(i);
      slv_bus.w_valid  = 1'b1; slv_bus.w.data  = 16'(32'hA000 + i); slv_bus.w.last = 1'b1;
      #1;
      chk("tp_aw_ready", 32'(slv_bus.aw_ready), 1);
      chk("tp_w_wire",   32'(mst_bus.w.data), 32'hA000 + i);
      if (i == 0) chk("tp_first_empty", 32'(mst_bus.aw_valid), 0);
      else begin
        chk("tp_mst_valid", 32'(mst_bus.aw_valid), 1);
        chk("tp_mst_addr",  32'(mst_bus.aw.addr), 32'h0100 + i - 1);
      end
      cyc();
    end
    slv_bus.aw_valid = 1'b0; slv_bus.w_valid = 1'b0;
    #1;
    chk("tp_last_valid", 32'(mst_bus.aw_valid), 1);
    chk("tp_last_addr",  32'(mst_bus.aw.addr), 32'h010F);
    chk("tp_wr_limit",   32'(slv_bus.aw_ready), 0);
    cyc();
    #1;
    chk("tp_drained", 32'(mst_bus.aw_valid), 0);
    do_reset();

    // Backpressure on AW depth 3
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      slv_bus.aw_valid = 1'b1; slv_bus.aw.addr = 16'(32'h0200 + acc);
      #1;
      chk("bp_ready", 32'(slv_bus.aw_ready), (i < 3) ? 1 : 0);
      if (slv_bus.aw_ready) acc++;
      cyc();
    end
    chk("bp_accepted", 32'(acc), 3);
    mst_bus.aw_ready = 1'b1;
    #1;
    chk("bp_full_pop_cycle", 32'(slv_bus.aw_ready), 0);
    chk("bp_head",           32'(mst_bus.aw.addr), 32'h0200);
    cyc();
    #1;
    chk("bp_ready_back", 32'(slv_bus.aw_ready), 1);
    chk("bp_next_head",  32'(mst_bus.aw.addr), 32'h0201);
    do_reset();

    // Outstanding read limit of 2
    mst_bus.ar_ready = 1'b1; slv_bus.r_ready = 1'b1;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      slv_bus.ar_valid = 1'b1; slv_bus.ar.addr = 16'(32'h0300 + acc);
      #1;
      chk("rl_ar_ready", 32'(slv_bus.ar_ready), (i < 2) ? 1 : 0);
      if (slv_bus.ar_ready) acc++;
      cyc();
    end
    mst_bus.r_valid = 1'b1; mst_bus.r.data = 16'hBEEF; mst_bus.r.last = 1'b1;
    #1;
    chk("rl_ar_stall",   32'(slv_bus.ar_ready), 0);
    chk("rl_r_in_ready", 32'(mst_bus.r_ready), 1);
    cyc();
    mst_bus.r_valid = 1'b0;
    #1;
    chk("rl_r_valid",      32'(slv_bus.r_valid), 1);
    chk("rl_r_data",       32'(slv_bus.r.data), 32'hBEEF);
    chk("rl_ar_still_off", 32'(slv_bus.ar_ready), 0);
    cyc();
    #1;
    chk("rl_ar_resume", 32'(slv_bus.ar_ready), 1);
    chk("rl_r_gone",    32'(slv_bus.r_valid), 0);
    do_reset();

    // Isolate with two writes outstanding
    mst_bus.aw_ready = 1'b1; mst_bus.w_ready = 1'b1; slv_bus.b_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      slv_bus.aw_valid = 1'b1; slv_bus.aw.addr = 16'(32'h0400 + i); slv_bus.aw.id = 2'(i);
      slv_bus.w_valid = 1'b1; slv_bus.w.last = 1'b1;
      cyc();
    end
    slv_bus.w_valid = 1'b0; slv_bus.aw.addr = 16'h0402; isolate_i = 1'b1;
    #1;
    chk("iso_aw_gated", 32'(slv_bus.aw_ready), 0);
    chk("iso_not_yet",  32'(isolated_o), 0);
    cyc();
    slv_bus.aw_valid = 1'b0;
    mst_bus.b_valid = 1'b1; mst_bus.b.id = 2'd0; mst_bus.b.resp = 2'd0;
    cyc();
    mst_bus.b.id = 2'd1;
    #1;
    chk("iso_b0_valid", 32'(slv_bus.b_valid), 1);
    chk("iso_b0_id",    32'(slv_bus.b.id), 0);
    cyc();
    mst_bus.b_valid = 1'b0;
    #1;
    chk("iso_b1_valid", 32'(slv_bus.b_valid), 1);
    chk("iso_b1_id",    32'(slv_bus.b.id), 1);
    cyc();
    #1;
    chk("iso_idle_cycle", 32'(isolated_o), 0);
    chk("iso_b_drained",  32'(slv_bus.b_valid), 0);
    cyc();
    #1;
    chk("iso_asserted",  32'(isolated_o), 1);
    chk("iso_aw_held",   32'(slv_bus.aw_ready), 0);
    cyc();
    isolate_i = 1'b0;
    #1;
    chk("iso_release_ready", 32'(slv_bus.aw_ready), 1);
    chk("iso_still_high",    32'(isolated_o), 1);
    cyc();
    #1;
    chk("iso_falls", 32'(isolated_o), 0);
    do_reset();

    // Mixed depths: W wire, R depth 5
    slv_bus.w_valid = 1'b1; slv_bus.w.data = 16'h0077; mst_bus.w_ready = 1'b0;
    #1;
    chk("mx_w_valid",     32'(mst_bus.w_valid), 1);
    chk("mx_w_ready_low", 32'(slv_bus.w_ready), 0);
    mst_bus.w_ready = 1'b1;
    #1;
    chk("mx_w_ready_high", 32'(slv_bus.w_ready), 1);
    slv_bus.w_valid = 1'b0;
    #1;
    chk("mx_w_valid_low", 32'(mst_bus.w_valid), 0);
    mst_bus.w_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 7; i++) begin
      mst_bus.r_valid = 1'b1; mst_bus.r.data = 16'(32'hC000 + acc); mst_bus.r.last = 1'b0;
      #1;
      chk("mx_r_ready", 32'(mst_bus.r_ready), (i < 5) ? 1 : 0);
      if (i == 0) chk("mx_r_push_cycle", 32'(slv_bus.r_valid), 0);
      if (mst_bus.r_ready) acc++;
      cyc();
    end
    chk("mx_r_absorbed", 32'(acc), 5);
    mst_bus.r_valid = 1'b0; slv_bus.r_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("mx_r_valid", 32'(slv_bus.r_valid), 1);
      chk("mx_r_data",  32'(slv_bus.r.data), 32'hC000 + i);
      cyc();
    end
    #1;
    chk("mx_r_empty", 32'(slv_bus.r_valid), 0);
    idle_inputs();

    // Reset with two entries in every buffer and two writes outstanding
    for (int i = 0; i < 2; i++) begin
      slv_bus.aw_valid = 1'b1; slv_bus.aw.addr = 16'(32'h0500 + i);
      slv_bus.ar_valid = 1'b1; slv_bus.ar.addr = 16'(32'h0600 + i);
      mst_bus.b_valid  = 1'b1; mst_bus.b.id = 2'(i);
      mst_bus.r_valid  = 1'b1; mst_bus.r.data = 16'(32'hD000 + i); mst_bus.r.last = 1'b1;
      cyc();
    end
    idle_inputs();
    #1;
    chk("pre_mst_aw_valid", 32'(mst_bus.aw_valid), 1);
    chk("pre_ar_limit",     32'(slv_bus.ar_ready), 0);
    chk("pre_slv_b_valid",  32'(slv_bus.b_valid), 1);
    chk("pre_slv_r_valid",  32'(slv_bus.r_valid), 1);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_aw_valid", 32'(mst_bus.aw_valid), 0);
    chk("mid_rst_ar_valid", 32'(mst_bus.ar_valid), 0);
    chk("mid_rst_b_valid",  32'(slv_bus.b_valid), 0);
    chk("mid_rst_r_valid",  32'(slv_bus.r_valid), 0);
    chk("mid_rst_ar_ready", 32'(slv_bus.ar_ready), 1);
    chk("mid_rst_aw_ready", 32'(slv_bus.aw_ready), 1);
    cyc();
    rst_i = 1'b0;
    mst_bus.aw_ready = 1'b1; mst_bus.w_ready = 1'b1; slv_bus.b_ready = 1'b1;
    slv_bus.aw_valid = 1'b1; slv_bus.aw.addr = 16'h0700; slv_bus.aw.id = 2'd3;
    slv_bus.w_valid  = 1'b1; slv_bus.w.data  = 16'h1234; slv_bus.w.last = 1'b1;
    #1;
    chk("post_aw_ready", 32'(slv_bus.aw_ready), 1);
    chk("post_w_data",   32'(mst_bus.w.data), 32'h1234);
    cyc();
    slv_bus.aw_valid = 1'b0; slv_bus.w_valid = 1'b0;
    #1;
    chk("post_mst_aw_valid", 32'(mst_bus.aw_valid), 1);
    chk("post_mst_aw_addr",  32'(mst_bus.aw.addr), 32'h0700);
    cyc();
    mst_bus.b_valid = 1'b1; mst_bus.b.id = 2'd3; mst_bus.b.resp = 2'd0;
    cyc();
    mst_bus.b_valid = 1'b0;
    #1;
    chk("post_b_valid", 32'(slv_bus.b_valid), 1);
    chk("post_b_id",    32'(slv_bus.b.id), 3);
    cyc();
    isolate_i = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      cyc();
      if (isolated_o) got = 1'b1;
    end
    chk("post_drain_isolated", 32'(got), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
